// File: rtl/ai_paddle_ctrl.sv
// ai_paddle_ctrl: AI paddle that tracks, holds or recentres once per movement tick,
// stepping by a difficulty-scaled amount with a dead zone and playfield clamping.
module ai_paddle_ctrl #(
    parameter int DISP_ROWS    = 800,
    parameter int DISP_COLS    = 600,
    parameter int PADDLE_SIDE  = 0,
    parameter int COORD_W      = 12,
    parameter int PADDLE_HALF  = 40,
    parameter int TICK_DIV     = 12000,
    parameter int TICK_W       = 20,
    parameter int MAX_STEP     = 4,
    parameter int DEAD_ZONE    = 2,
    parameter int REACT_MARGIN = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [COORD_W-1:0] ball_center_row,
    input  logic [COORD_W-1:0] ball_center_col,
    input  logic [1:0]         ball_direction,
    input  logic [1:0]         difficulty,
    output logic [COORD_W-1:0] paddle_center_row,
    output logic [1:0]         paddle_dir,
    output logic [1:0]         ai_state
);
    typedef enum logic [1:0] {IDLE = 2'b00, HOLD = 2'b01, TRACK = 2'b10, RETURN = 2'b11} state_t;

    localparam logic [COORD_W-1:0] LO     = COORD_W'(PADDLE_HALF);
    localparam logic [COORD_W-1:0] HI     = COORD_W'(DISP_ROWS - 1 - PADDLE_HALF);
    localparam logic [COORD_W-1:0] MID    = COORD_W'(DISP_ROWS / 2);
    localparam logic [COORD_W-1:0] ZONE_L = COORD_W'(DISP_COLS / 2 - REACT_MARGIN);
    localparam logic [COORD_W-1:0] ZONE_R = COORD_W'(DISP_COLS / 2 + REACT_MARGIN);
    localparam logic [COORD_W:0]   STEP_MAX = (COORD_W+1)'(MAX_STEP);
    localparam logic [COORD_W:0]   DZ       = (COORD_W+1)'(DEAD_ZONE);
    localparam logic [TICK_W-1:0]  T_LAST   = TICK_W'(TICK_DIV - 1);

    state_t              state_q, state_d, eval;
    logic [TICK_W-1:0]   cnt_q, cnt_d;
    logic [COORD_W-1:0]  pos_q, pos_d, ball_c, target, new_pos;
    logic [1:0]          dir_q, dir_d;
    logic signed [COORD_W:0] err;
    logic [COORD_W:0]    mag, step, mv, sum;
    logic [2:0]          req;
    logic                tick, approach, in_zone, moving;
    logic                unused_vdir;

    assign unused_vdir = ball_direction[0];

    always_comb begin
        tick     = enable && cnt_q == T_LAST;
        approach = PADDLE_SIDE == 0 ? !ball_direction[1] : ball_direction[1];
        in_zone  = PADDLE_SIDE == 0 ? ball_center_col < ZONE_L : ball_center_col > ZONE_R;
        eval     = approach ? (in_zone ? TRACK : HOLD) : RETURN;
        ball_c   = ball_center_row < LO ? LO : ball_center_row > HI ? HI : ball_center_row;
        target   = state_q == TRACK ? ball_c : MID;
        err      = $signed({1'b0, target}) - $signed({1'b0, pos_q});
        mag      = err[COORD_W] ? -err : err;
        req      = {1'b0, difficulty} + 3'd1;
        step     = (COORD_W+1)'(req) > STEP_MAX ? STEP_MAX : (COORD_W+1)'(req);
        mv       = mag < step ? mag : step;
        sum      = err[COORD_W] ? {1'b0, pos_q} - mv : {1'b0, pos_q} + mv;
        // Target is already in range; the clamp keeps the position legal regardless.
        new_pos  = sum < {1'b0, LO} ? LO : sum > {1'b0, HI} ? HI : sum[COORD_W-1:0];
        moving   = (state_q == TRACK || state_q == RETURN) && mag > DZ;
        cnt_d    = (!enable || tick) ? '0 : cnt_q + 1'b1;
        state_d  = !enable ? IDLE : state_q == IDLE ? HOLD : tick ? eval : state_q;
        pos_d    = (enable && state_q != IDLE && tick && moving) ? new_pos : pos_q;
        dir_d    = !enable ? 2'b00 :
                   (state_q != IDLE && tick) ? (moving ? (err[COORD_W] ? 2'b10 : 2'b01) : 2'b00) :
                   dir_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            pos_q   <= MID;
            dir_q   <= 2'b00;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
        end
    end

    assign paddle_center_row = pos_q;
    assign paddle_dir        = dir_q;
    assign ai_state          = state_q;
endmodule
